// File: rtl/shift_rotate_seq_pkg.sv
// ---- shift_seq_pkg : op/state encodings and shift-amount helper for shift_rotate_seq (rev 1.0)
`default_nettype none

package shift_seq_pkg;

  localparam int SHIFT_AMT_W = 6;
  localparam int OP_W        = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ROR  = 3'd0,
    OP_ROL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHRA = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Rotates wrap mod 32; plain shifts saturate at 32; illegal ops do nothing.
  function automatic logic [SHIFT_AMT_W-1:0] effective_amount(
    input logic [OP_W-1:0] op,
    input logic [31:0]     num_shifts
  );
    logic [SHIFT_AMT_W-1:0] amt;
    amt = '0;
    case (op)
      OP_ROR, OP_ROL:          amt = {1'b0, num_shifts[4:0]};
      OP_SHR, OP_SHL, OP_SHRA: amt = (|num_shifts[31:5]) ? 6'd32 : {1'b0, num_shifts[4:0]};
      default:                 amt = '0;
    endcase
    return amt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_rotate_seq_if.sv
// ---- shift_rotate_seq_if : request/result bus of the shift/rotate sequencer (rev 1.0)
`default_nettype none

interface shift_rotate_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] in;
  logic [31:0]      num_shifts;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, op, in, num_shifts,
    input  busy, done, out
  );

  modport slave (
    input  start, op, in, num_shifts,
    output busy, done, out
  );
endinterface

`default_nettype wire

// File: rtl/shift_rotate_seq_step_unit.sv
// ---- shift_step_unit : one combinational shift/rotate step of 0..32 positions (rev 1.0)
`default_nettype none

module shift_step_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       data_i,
  input  logic [OP_W-1:0]        op_i,
  input  logic [SHIFT_AMT_W-1:0] step_i,
  input  logic                   sign_i,
  output logic [WIDTH-1:0]       data_o
);

  localparam logic [SHIFT_AMT_W-1:0] c_width = SHIFT_AMT_W'(WIDTH);

  logic [WIDTH-1:0] w_right;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_wrap_r;
  logic [WIDTH-1:0] w_wrap_l;
  logic [WIDTH-1:0] w_fill;

  // A zero step makes the wrap shift equal WIDTH, which yields zero.
  assign w_right  = data_i >> step_i;
  assign w_left   = data_i << step_i;
  assign w_wrap_r = data_i << (c_width - step_i);
  assign w_wrap_l = data_i >> (c_width - step_i);
  assign w_fill   = sign_i ? ~({WIDTH{1'b1}} >> step_i) : '0;

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_ROR:  data_o = w_right | w_wrap_r;
      OP_ROL:  data_o = w_left | w_wrap_l;
      OP_SHR:  data_o = w_right;
      OP_SHL:  data_o = w_left;
      OP_SHRA: data_o = w_right | w_fill;
      default: data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_rotate_seq.sv
// ---- shift_rotate_seq : multi-cycle ROR/ROL/SHR/SHL/SHRA sequencer, up to STEP bits per cycle (rev 1.0)
// ---- Optional macro SHIFT_SEQ_ZERO_BYPASS_EN: zero-amount requests skip the RUN state.
`default_nettype none

module shift_rotate_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic              clock_i,
  input  logic              clear_i,
  shift_rotate_seq_if.slave bus
);

  localparam logic [SHIFT_AMT_W-1:0] c_step = SHIFT_AMT_W'(STEP);

  state_e                 state_q;
  logic [SHIFT_AMT_W-1:0] count_q;
  logic [WIDTH-1:0]       data_q;
  logic [WIDTH-1:0]       out_q;
  logic [OP_W-1:0]        op_q;
  logic                   sign_q;
  logic                   busy_q;
  logic                   done_q;

  logic [SHIFT_AMT_W-1:0] w_amt;
  logic [SHIFT_AMT_W-1:0] w_step;
  logic [SHIFT_AMT_W-1:0] count_d;
  logic [WIDTH-1:0]       data_d;

  assign w_amt   = effective_amount(bus.op, bus.num_shifts);
  assign w_step  = (count_q < c_step) ? count_q : c_step;
  assign count_d = count_q - w_step;

  shift_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .step_i (w_step),
    .sign_i (sign_q),
    .data_o (data_d)
  );

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      data_q  <= '0;
      out_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            sign_q  <= bus.in[WIDTH-1];
            data_q  <= bus.in;
            count_q <= w_amt;
            busy_q  <= 1'b1;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
            if (w_amt == '0) begin
              state_q <= S_DONE;
              out_q   <= bus.in;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
`else
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          // A zero remaining count still costs this one (no-op) step.
          data_q  <= data_d;
          count_q <= count_d;
          if (count_d == '0) begin
            state_q <= S_DONE;
            out_q   <= data_d;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_rotate_seq.sv
// ---- tb_shift_rotate_seq : vector table, random ops against a bit-serial model, and corner sequences (rev 1.0)
`default_nettype none

module tb_shift_rotate_seq;

  localparam int STEP = 4;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_rotate_seq_if #(.WIDTH(32)) bus ();

  shift_rotate_seq #(.WIDTH(32), .STEP(STEP)) dut (
    .clock_i (clk),
    .clear_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] din;
    logic [31:0] n;
    logic [31:0] exp_out;
    int          runs;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int eff_amt(input logic [2:0] op, input logic [31:0] n);
    if (op <= 3'd1) return int'(n % 32);
    if (op <= 3'd4) return (n >= 32) ? 32 : int'(n);
    return 0;
  endfunction

  // Reference: apply the operation one bit position at a time.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] d, input int amt);
    logic [31:0] v;
    v = d;
    for (int i = 0; i < amt; i++) begin
      case (op)
        3'd0: v = {v[0], v[31:1]};
        3'd1: v = {v[30:0], v[31]};
        3'd2: v = {1'b0, v[31:1]};
        3'd3: v = {v[30:0], 1'b0};
        3'd4: v = {v[31], v[31:1]};
        default: v = v;
      endcase
    end
    return v;
  endfunction

  function automatic int done_edge(input int amt, input int runs);
    if (c_bypass && amt == 0) return 0;
    return runs;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [31:0] n,
                        input logic [31:0] exp_out, input int exp_k, input bit spam, input string name);
    int k;
    logic [31:0] prev_out;
    @(negedge clk);
    prev_out       = bus.out;
    bus.start      = 1'b1;
    bus.op         = o;
    bus.in         = d;
    bus.num_shifts = n;
    @(posedge clk);
    k = 0;
    @(negedge clk);
    chk({name, " busy after accept"}, {31'd0, bus.busy}, 32'd1);
    if (!bus.done) chk({name, " out held during run"}, bus.out, prev_out);
    while (!bus.done && k < 64) begin
      if (spam) begin
        bus.start      = 1'b1;
        bus.op         = 3'($urandom_range(0, 7));
        bus.in         = $urandom;
        bus.num_shifts = $urandom_range(0, 40);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    if (!spam) bus.start = 1'b0;
    chk({name, " latency"}, 32'(k), 32'(exp_k));
    chk({name, " done"}, {31'd0, bus.done}, 32'd1);
    chk({name, " out"}, bus.out, exp_out);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, " done drops"}, {31'd0, bus.done}, 32'd0);
    chk({name, " idle after done"}, {31'd0, bus.busy}, 32'd0);
    chk({name, " out held"}, bus.out, exp_out);
  endtask

  initial begin
    int dones;
    bus.start      = 1'b0;
    bus.op         = '0;
    bus.in         = '0;
    bus.num_shifts = '0;

    tbl[0] = '{3'd0, 32'h0000_00F1, 32'd4,   32'h1000_000F, 1};
    tbl[1] = '{3'd1, 32'h8000_0001, 32'd33,  32'h0000_0003, 1};
    tbl[2] = '{3'd3, 32'hFFFF_FFFF, 32'd40,  32'h0000_0000, 8};
    tbl[3] = '{3'd4, 32'h8000_0000, 32'd31,  32'hFFFF_FFFF, 8};
    tbl[4] = '{3'd2, 32'h8000_0000, 32'd31,  32'h0000_0001, 8};
    tbl[5] = '{3'd7, 32'h1234_5678, 32'd0,   32'h1234_5678, 1};
    tbl[6] = '{3'd5, 32'hA5A5_A5A5, 32'd9,   32'hA5A5_A5A5, 1};
    tbl[7] = '{3'd0, 32'h1234_5678, 32'd32,  32'h1234_5678, 1};
    tbl[8] = '{3'd0, 32'h1234_5678, 32'd5,   32'hC091_A2B3, 2};
    tbl[9] = '{3'd4, 32'h7FFF_FFFF, 32'd100, 32'h0000_0000, 8};

    @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset out", bus.out, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].din, tbl[i].n, tbl[i].exp_out,
             done_edge(eff_amt(tbl[i].op, tbl[i].n), tbl[i].runs), 1'b0,
             $sformatf("vec%0d", i));
    end

    // start held high through RUN and DONE must not queue a second operation
    run_op(3'd4, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 8, 1'b1, "spam");
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    chk("spam no extra op", 32'(dones), 32'd0);

    // clear during the second RUN cycle of SHL by 20
    run_op(3'd0, 32'h0000_00F1, 32'd4, 32'h1000_000F, 1, 1'b0, "pre-clear");
    @(negedge clk);
    bus.start      = 1'b1;
    bus.op         = 3'd3;
    bus.in         = 32'hFFFF_FFFF;
    bus.num_shifts = 32'd20;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("clear busy", {31'd0, bus.busy}, 32'd0);
    chk("clear out", bus.out, 32'd0);
    chk("clear done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("clear no done", 32'(dones), 32'd0);
    run_op(3'd1, 32'h8000_0001, 32'd1, 32'h0000_0003, 1, 1'b0, "post-clear");

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] d;
      logic [31:0] n;
      int          amt;
      int          runs;
      o    = 3'($urandom_range(0, 7));
      d    = $urandom;
      n    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      amt  = eff_amt(o, n);
      runs = (amt == 0) ? 1 : (amt + STEP - 1) / STEP;
      run_op(o, d, n, model(o, d, amt), done_edge(amt, runs), 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
